// File: rtl/ntt_pkg.sv
// Shared definitions for the NTT sequencer: geometry, latencies, FSM states
// and the write-back delay-line entry.
package ntt_pkg;

   localparam int N       = 256;
   localparam int LOG_N   = 8;
   localparam int ADDR_W  = 8;
   localparam int RD_LAT  = 1;
   localparam int BFU_LAT = 4;

   // Derived constants
   localparam int HALF_N  = N / 2;
   localparam int IDX_W   = ADDR_W - 1;          // butterfly index within a layer
   localparam int LAYER_W = $clog2(LOG_N);       // layer counter width
   localparam int WB_DLY  = RD_LAT + BFU_LAT;    // read-to-write distance, cycles
   localparam int DRN_W   = $clog2(WB_DLY);      // drain counter width

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DRAIN,
      FINISH
   } ntt_state_e;

   typedef logic [ADDR_W-1:0] coef_addr_t;

   // One stage of the write-back delay line
   typedef struct packed {
      logic       en;
      coef_addr_t a;
      coef_addr_t b;
   } wb_t;

endpackage

// File: rtl/ntt_addr_gen.sv
// Butterfly address generator. Holds the layer and in-layer index counters
// and derives the pair addresses and twiddle index arithmetically from them.
// The counters always point at the next butterfly to be issued; after the
// final butterfly of the final layer they fall back to layer 0, index 0.
module ntt_addr_gen
   import ntt_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       step,
   input  logic       intt,
   output coef_addr_t rd_a,
   output coef_addr_t rd_b,
   output coef_addr_t tw_addr,
   output logic       last_in_layer,
   output logic       last_layer
);

   logic [IDX_W-1:0]   idx_reg;
   logic [LAYER_W-1:0] layer_reg;

   logic [LAYER_W-1:0] lg;
   coef_addr_t         idx_ext;
   coef_addr_t         span;
   coef_addr_t         low;
   coef_addr_t         grp;
   coef_addr_t         a_val;

   assign last_in_layer = (idx_reg == IDX_W'(HALF_N - 1));
   assign last_layer    = (layer_reg == LAYER_W'(LOG_N - 1));

   // Advance one butterfly per step; end of layer is detected by index value
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_reg   <= '0;
         layer_reg <= '0;
      end else if (step) begin
         if (last_in_layer) begin
            idx_reg   <= '0;
            layer_reg <= last_layer ? '0 : layer_reg + LAYER_W'(1);
         end else begin
            idx_reg   <= idx_reg + IDX_W'(1);
         end
      end
   end

   // Split the index into group and offset around the butterfly span:
   // forward spans shrink N/2..1, inverse spans grow 1..N/2
   always_comb begin
      lg      = intt ? layer_reg : LAYER_W'(LOG_N - 1) - layer_reg;
      idx_ext = coef_addr_t'(idx_reg);
      span    = coef_addr_t'(1) << lg;
      low     = idx_ext & (span - coef_addr_t'(1));
      grp     = idx_ext >> lg;
      a_val   = ((grp << lg) << 1) | low;
   end

   // Pair addresses and twiddle index; inverse counts down from N-1 and
   // relies on modulo-2^ADDR_W arithmetic when the start value is N-1
   always_comb begin
      rd_a = a_val;
      rd_b = a_val | span;
      if (intt) begin
         tw_addr = (((coef_addr_t'(HALF_N) >> lg) << 1) - coef_addr_t'(1)) - grp;
      end else begin
         tw_addr = (coef_addr_t'(HALF_N) >> lg) + grp;
      end
   end

endmodule

// File: rtl/ntt_ctrl.sv
// NTT/INTT sequencer for a single pipelined butterfly unit.
// Issues N/2 butterflies per layer, drains RD_LAT+BFU_LAT cycles between
// layers so every write lands before the next layer reads, and delays the
// read addresses to form the write-back addresses.
// Optional feature: define NTT_CTRL_PERF_EN to add the o_cycles busy counter.
module ntt_ctrl
   import ntt_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   input  logic              i_intt,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_rd_en,
   output logic [ADDR_W-1:0] o_rd_addr_a,
   output logic [ADDR_W-1:0] o_rd_addr_b,
   output logic [ADDR_W-1:0] o_tw_addr,
   output logic              o_bfu_intt,
   output logic              o_bfu_skip,
   output logic              o_wr_en,
   output logic [ADDR_W-1:0] o_wr_addr_a,
   output logic [ADDR_W-1:0] o_wr_addr_b
`ifdef NTT_CTRL_PERF_EN
   ,
   output logic [15:0]       o_cycles
`endif
);

   ntt_state_e       state_reg;
   ntt_state_e       state_next;
   logic [DRN_W-1:0] drain_cnt_reg;
   logic             end_layer_reg;   // butterfly on the outputs closes its layer
   logic             end_op_reg;      // ... and that layer is the last one
   logic             issue;           // a butterfly is launched at this edge
   logic             accept;          // i_start is taken at this edge
   logic             gen_intt;

   coef_addr_t       gen_a;
   coef_addr_t       gen_b;
   coef_addr_t       gen_tw;
   logic             gen_last_in_layer;
   logic             gen_last_layer;

   wb_t              wb_reg [WB_DLY];

   // The mode register only changes on acceptance, so the generator sees the
   // incoming request mode for the very first butterfly
   assign gen_intt   = accept ? i_intt : o_bfu_intt;
   assign o_bfu_skip = 1'b0;

   ntt_addr_gen u_addr_gen (
      .clk           (i_clk),
      .rst           (i_rst),
      .step          (issue),
      .intt          (gen_intt),
      .rd_a          (gen_a),
      .rd_b          (gen_b),
      .tw_addr       (gen_tw),
      .last_in_layer (gen_last_in_layer),
      .last_layer    (gen_last_layer)
   );

   // State register
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic and issue/accept strobes
   always_comb begin
      state_next = state_reg;
      issue      = 1'b0;
      accept     = 1'b0;
      case (state_reg)
         IDLE: begin
            if (i_start) begin
               accept     = 1'b1;
               issue      = 1'b1;
               state_next = ISSUE;
            end
         end
         ISSUE: begin
            if (end_layer_reg) begin
               state_next = DRAIN;
            end else begin
               issue = 1'b1;
            end
         end
         DRAIN: begin
            if (drain_cnt_reg == DRN_W'(WB_DLY - 1)) begin
               if (end_op_reg) begin
                  state_next = FINISH;
               end else begin
                  issue      = 1'b1;
                  state_next = ISSUE;
               end
            end
         end
         FINISH: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Drain length counter, parked at 0 outside DRAIN
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         drain_cnt_reg <= '0;
      end else if (state_reg != DRAIN) begin
         drain_cnt_reg <= '0;
      end else begin
         drain_cnt_reg <= drain_cnt_reg + DRN_W'(1);
      end
   end

   // Remember whether the butterfly just issued ends its layer / the operation
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         end_layer_reg <= 1'b0;
         end_op_reg    <= 1'b0;
      end else if (issue) begin
         end_layer_reg <= gen_last_in_layer;
         end_op_reg    <= gen_last_in_layer & gen_last_layer;
      end
   end

   // Registered read-side and status outputs
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_busy      <= 1'b0;
         o_done      <= 1'b0;
         o_rd_en     <= 1'b0;
         o_rd_addr_a <= '0;
         o_rd_addr_b <= '0;
         o_tw_addr   <= '0;
         o_bfu_intt  <= 1'b0;
      end else begin
         o_busy      <= (state_next == ISSUE) || (state_next == DRAIN);
         o_done      <= (state_next == FINISH);
         o_rd_en     <= issue;
         o_rd_addr_a <= issue ? gen_a  : '0;
         o_rd_addr_b <= issue ? gen_b  : '0;
         o_tw_addr   <= issue ? gen_tw : '0;
         if (accept) begin
            o_bfu_intt <= i_intt;
         end
      end
   end

   // Write-back delay line: read strobe and pair addresses shifted WB_DLY cycles
   for (genvar gi = 0; gi < WB_DLY; gi++) begin : g_wb
      if (gi == 0) begin : g_head
         // First stage captures the registered read request
         always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
               wb_reg[gi] <= '0;
            end else begin
               wb_reg[gi] <= '{en: o_rd_en, a: o_rd_addr_a, b: o_rd_addr_b};
            end
         end
      end else begin : g_tail
         // Later stages shift the previous stage along
         always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
               wb_reg[gi] <= '0;
            end else begin
               wb_reg[gi] <= wb_reg[gi-1];
            end
         end
      end
   end

   assign o_wr_en     = wb_reg[WB_DLY-1].en;
   assign o_wr_addr_a = wb_reg[WB_DLY-1].a;
   assign o_wr_addr_b = wb_reg[WB_DLY-1].b;

`ifdef NTT_CTRL_PERF_EN
   // Busy-cycle counter: cleared on acceptance, frozen once busy drops
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_cycles <= '0;
      end else if (accept) begin
         o_cycles <= '0;
      end else if (o_busy) begin
         o_cycles <= o_cycles + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_ntt_ctrl.sv
// Self-checking bench for ntt_ctrl. A cycle-indexed model of the operation
// (tuple tables built from the NTT loop nests plus a per-cycle schedule) is
// compared against the DUT on every falling edge; a scoreboard checks that
// no address is read before its previous-layer write has happened.
module tb_ntt_ctrl;
   import ntt_pkg::*;

   localparam int NBF      = HALF_N * LOG_N;     // butterflies per operation
   localparam int LAYER_CY = HALF_N + WB_DLY;    // cycles per layer
   localparam int BUSY_CY  = LAYER_CY * LOG_N;   // 1064
   localparam int DONE_CY  = BUSY_CY + 1;        // 1065

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic              intt;
   logic              busy, done, rd_en, bfu_intt, bfu_skip, wr_en;
   logic [ADDR_W-1:0] rd_a, rd_b, tw, wr_a, wr_b;
`ifdef NTT_CTRL_PERF_EN
   logic [15:0]       cycles;
`endif

   int total = 0;
   int bad   = 0;

   // Model tables: [mode][butterfly] -> (a, b, twiddle)
   int exp_a [2][NBF];
   int exp_b [2][NBF];
   int exp_t [2][NBF];

   // Model run state
   bit mact  = 1'b0;
   int mcyc  = 0;
   int mmode = 0;
   int rcnt [N];
   int wcnt [N];

   always #5 clk = ~clk;

   ntt_ctrl dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_start     (start),
      .i_intt      (intt),
      .o_busy      (busy),
      .o_done      (done),
      .o_rd_en     (rd_en),
      .o_rd_addr_a (rd_a),
      .o_rd_addr_b (rd_b),
      .o_tw_addr   (tw),
      .o_bfu_intt  (bfu_intt),
      .o_bfu_skip  (bfu_skip),
      .o_wr_en     (wr_en),
      .o_wr_addr_a (wr_a),
      .o_wr_addr_b (wr_b)
`ifdef NTT_CTRL_PERF_EN
      ,
      .o_cycles    (cycles)
`endif
   );

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
      end
   endtask

   // Build the reference tuple lists straight from the NTT loop nests
   task automatic build_model();
      int k, len, t;
      k = 0; t = 1;
      for (int l = 0; l < LOG_N; l++) begin
         len = N >> (l + 1);
         for (int s = 0; s < N; s += 2 * len) begin
            for (int j = s; j < s + len; j++) begin
               exp_a[0][k] = j; exp_b[0][k] = j + len; exp_t[0][k] = t; k++;
            end
            t++;
         end
      end
      k = 0; t = N - 1; len = 1;
      for (int l = 0; l < LOG_N; l++) begin
         for (int s = 0; s < N; s += 2 * len) begin
            for (int j = s; j < s + len; j++) begin
               exp_a[1][k] = j; exp_b[1][k] = j + len; exp_t[1][k] = t; k++;
            end
            t--;
         end
         len = len * 2;
      end
   endtask

   // Per-cycle compare against the model schedule
   always @(negedge clk) begin
      bit exp_rd, exp_wr;
      int k, kw, rc, nbad;
      if (rst) begin
         chk("rst_busy", busy, 0);
         chk("rst_done", done, 0);
         chk("rst_rd_en", rd_en, 0);
         chk("rst_rd_a", rd_a, 0);
         chk("rst_tw", tw, 0);
         chk("rst_wr_en", wr_en, 0);
         chk("rst_wr_b", wr_b, 0);
         chk("rst_bfu_intt", bfu_intt, 0);
         mact = 1'b0; mcyc = 0; mmode = 0;
      end else begin
         exp_rd = 1'b0; exp_wr = 1'b0; k = 0; kw = 0;
         if (mact && mcyc <= BUSY_CY && ((mcyc - 1) % LAYER_CY) < HALF_N) begin
            exp_rd = 1'b1;
            k = ((mcyc - 1) / LAYER_CY) * HALF_N + (mcyc - 1) % LAYER_CY;
         end
         rc = mcyc - WB_DLY;
         if (mact && rc >= 1 && rc <= BUSY_CY && ((rc - 1) % LAYER_CY) < HALF_N) begin
            exp_wr = 1'b1;
            kw = ((rc - 1) / LAYER_CY) * HALF_N + (rc - 1) % LAYER_CY;
         end
         chk("busy", busy, int'(mact && mcyc <= BUSY_CY));
         chk("done", done, int'(mact && mcyc == DONE_CY));
         chk("rd_en", rd_en, int'(exp_rd));
         chk("wr_en", wr_en, int'(exp_wr));
         chk("bfu_intt", bfu_intt, mmode);
         chk("bfu_skip", bfu_skip, 0);
         if (exp_rd) begin
            chk("rd_a", rd_a, exp_a[mmode][k]);
            chk("rd_b", rd_b, exp_b[mmode][k]);
            chk("tw", tw, exp_t[mmode][k]);
         end
         if (exp_wr) begin
            chk("wr_a", wr_a, exp_a[mmode][kw]);
            chk("wr_b", wr_b, exp_b[mmode][kw]);
         end
         // Read-after-write: the k-th read of an address needs k earlier writes
         if (rd_en) begin
            chk("raw_a", wcnt[rd_a], rcnt[rd_a]);
            chk("raw_b", wcnt[rd_b], rcnt[rd_b]);
            rcnt[rd_a]++; rcnt[rd_b]++;
         end
         if (wr_en) begin
            wcnt[wr_a]++; wcnt[wr_b]++;
         end
         if (mact && mcyc == DONE_CY) begin
            nbad = 0;
            for (int i = 0; i < N; i++) if (wcnt[i] != LOG_N) nbad++;
            chk("write_once_per_layer", nbad, 0);
`ifdef NTT_CTRL_PERF_EN
            chk("perf_cycles", cycles, 1064);
`endif
         end
         // Advance the model
         if (mact) begin
            mcyc++;
            if (mcyc > DONE_CY) mact = 1'b0;
         end else if (start) begin
            mact = 1'b1; mcyc = 1; mmode = int'(intt);
            for (int i = 0; i < N; i++) begin rcnt[i] = 0; wcnt[i] = 0; end
         end
      end
   end

   // One operation with an optional stray start pulse (flipped mode) at cycle pulse_at
   task automatic run_op(input bit mode, input int pulse_at);
      int nb;
      nb = 0;
      @(posedge clk); #1; start = 1'b1; intt = mode;
      for (int c = 0; c < DONE_CY + 6; c++) begin
         @(posedge clk); #1;
         start = (c + 1 == pulse_at);
         intt  = (c + 1 == pulse_at) ? ~mode : mode;
         @(negedge clk);
         if (busy) nb++;
      end
      chk("busy_len", nb, 1064);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; intt = 1'b0;
      build_model();
      // Literal pins on the model tables
      chk("pin_f_first_a", exp_a[0][0], 0);
      chk("pin_f_first_b", exp_b[0][0], 128);
      chk("pin_f_first_tw", exp_t[0][0], 1);
      chk("pin_f_c128_b", exp_b[0][127], 255);
      chk("pin_f_l1_tw", exp_t[0][128], 2);
      chk("pin_f_l7_a", exp_a[0][7*128+5], 10);
      chk("pin_f_l7_b", exp_b[0][7*128+5], 11);
      chk("pin_f_l7_tw", exp_t[0][7*128+5], 133);
      chk("pin_i_first_b", exp_b[1][0], 1);
      chk("pin_i_first_tw", exp_t[1][0], 255);
      chk("pin_i_last_b", exp_b[1][7*128+3], 131);
      chk("pin_i_last_tw", exp_t[1][7*128+3], 1);

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      repeat (3) @(posedge clk);

      $display("op forward");
      run_op(1'b0, -1);
      $display("op inverse");
      run_op(1'b1, -1);
      $display("op forward with stray start at cycle 300");
      run_op(1'b0, 300);

      $display("op start held high");
      @(posedge clk); #1; start = 1'b1; intt = 1'b1;
      repeat (1500) @(posedge clk);
      #1 start = 1'b0;
      repeat (1100) @(posedge clk);

      $display("op reset abort at cycle 500");
      @(posedge clk); #1; start = 1'b1; intt = 1'b0;
      @(posedge clk); #1; start = 1'b0;
      repeat (499) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("async_busy", busy, 0);
      chk("async_rd_en", rd_en, 0);
      chk("async_wr_en", wr_en, 0);
      chk("async_done", done, 0);
      repeat (2) @(posedge clk);
      #3 rst = 1'b0;
      repeat (20) @(posedge clk);

      $display("op forward after reset");
      run_op(1'b0, -1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
